div_unit_32bits: RTL and testbench
==================================

Name: div_unit_32bits

Overview:
- Multi-cycle RV32M divide unit: DIV, DIVU, REM, REMU.
- It is the subtract-side counterpart of the core's combinational adder. A radix-2 restoring divider performs one trial subtraction per clock.
- It sits in the EX stage beside the ALU. The pipeline stalls on busy and takes the result on done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- rst, input, 1, reset, synchronous active-high.
- start, input, 1, request pulse; sampled only while idle.
- op, input, 2, operation select = funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a, input, 32, dividend (rs1); sampled with start.
- b, input, 32, divisor (rs2); sampled with start.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse; y is valid in that cycle.
- y, output, 32, quotient or remainder per op; held until the next done.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, y=0; all internal registers cleared.
  - rst mid-operation aborts immediately. No done is produced for the aborted op.
- States:
  - IDLE: start=1 moves to CALC. Load:
    - |a| and |b| (absolute values only for signed ops);
    - op;
    - sign flags: qneg = a[31]^b[31], rneg = a[31] (signed ops only);
    - rem=33'b0, cnt=0.
  - CALC: each cycle performs one iteration.
    - Shift {rem,quo} left by 1, bringing in the dividend MSB.
    - trial = rem − {1'b0,divisor}, 33 bits.
    - If trial is non-negative: rem=trial and quo LSB=1. Otherwise rem is unchanged and quo LSB=0.
    - cnt increments; after the iteration where cnt=31, move to FIX.
  - FIX:
    - Apply sign: quotient negated if qneg; remainder negated if rneg.
    - Select y by op[1]; done=1; busy=0; go to IDLE.
  - Special cases are resolved in FIX:
    - Divisor zero: quotient=32'hFFFF_FFFF, remainder=a (original, unsigned or signed).
    - Signed overflow, a=32'h8000_0000 and b=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
- Latency:
  - start sampled at edge N; done is high in the cycle following edge N+33, i.e. 34 cycles.
  - busy is high for 33 cycles.
  - Back-to-back: start is accepted in the cycle done is high (the FIX→IDLE edge already occurred), so the throughput is one op per 34 cycles.
- Handshake:
  - start while busy=1 is ignored. Operands must not be assumed held after the start cycle.
  - done never coincides with busy.
- Width rules:
  - Internal remainder is 33 bits to avoid overflow in the trial subtraction.
  - Negation is two's complement, modulo 2^32.
  - |−2^31| is 32'h8000_0000 treated as unsigned.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - Divisor-zero and signed-overflow cases are detected in IDLE at start.
  - The FSM goes directly to FIX, so done comes 2 cycles after start and busy is high for 1 cycle.
- Undefined:
  - Every op takes the full 34 cycles. Results are identical in both builds.

Decomposition:
- Package div_pkg:
  - XLEN=32;
  - op encodings OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11;
  - state enum IDLE/CALC/FIX.
- Sub-module div_step (combinational):
  - inputs: 33-bit shifted remainder, 32-bit divisor;
  - outputs: next remainder and quotient bit;
  - one instance in div_unit_32bits.

Test Plan:
- DIVU a=100, b=7 → done at start+34, y=14. REMU with the same operands → y=2. busy high for exactly 33 cycles.
- DIV a=−7 (32'hFFFF_FFF9), b=2 → y=32'hFFFF_FFFD (−3). REM → y=32'hFFFF_FFFF (−1). DIV a=7, b=−2 → y=−3.
- Divide by zero:
  - DIVU a=5, b=0 → y=32'hFFFF_FFFF.
  - REM a=−5, b=0 → y=32'hFFFF_FFFB.
  - With DIV_EARLY_OUT_EN, done arrives at start+2.
- Overflow: DIV a=32'h8000_0000, b=32'hFFFF_FFFF → y=32'h8000_0000; REM → y=0. DIVU with the same operands → y=0, and REMU → y=32'h8000_0000.
- Control:
  - Pulse start at cycle 5 of busy with different operands → ignored; the original result is returned.
  - Assert rst at iteration 10 → busy=0, done=0, y=0 next cycle, and no done afterwards.
  - A fresh start then completes normally.
- Back-to-back: issue start in the done cycle → second op accepted. Results 100/7=14, then 0xFFFFFFFF/3 DIVU=32'h5555_5555, with done pulses 34 cycles apart.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the RV32M divide unit: operand width, op encodings,
// FSM state codes and a small absolute-value helper.
package div_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] FIX  = 2'b10;

  typedef logic [1:0] state_t;

  // Magnitude of a signed operand; the most negative value maps to 2^31 as unsigned.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference when it does not go negative.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   rem_shift_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] trial;

  assign trial   = rem_shift_i - {1'b0, divisor_i};
  assign q_bit_o = ~trial[XLEN];
  // Result is always below the divisor, so it fits back into XLEN bits.
  assign rem_o   = q_bit_o ? trial[XLEN-1:0] : rem_shift_i[XLEN-1:0];

endmodule

// File: rtl/div_unit_32bits.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one restoring step per clock.
// Optional build macro DIV_EARLY_OUT_EN skips the iterations for divide-by-zero and signed overflow.
module div_unit_32bits #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] y
);

  import div_pkg::*;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] y_q, y_d;

  logic            is_signed;
  logic            start_div0;
  logic            start_ovf;
  logic [XLEN-1:0] step_rem;
  logic            step_qbit;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  div_step u_step (
    .rem_shift_i ({1'b0, rem_q, quo_q[XLEN-1]}),
    .divisor_i   (divisor_q),
    .rem_o       (step_rem),
    .q_bit_o     (step_qbit)
  );

  assign is_signed  = ~op[0];
  assign start_div0 = (b == '0);
  assign start_ovf  = is_signed && (a == INT_MIN) && (b == '1);

  // Special cases override the iterated result so both builds agree.
  assign quo_fix = div0_q ? '1 :
                   ovf_q  ? INT_MIN :
                   qneg_q ? -quo_q : quo_q;
  assign rem_fix = div0_q ? a_q :
                   ovf_q  ? '0 :
                   rneg_q ? -rem_q : rem_q;

  // NOTE: every *_d starts from its held value, so no path through the case leaves a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    y_d       = y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          a_d       = a;
          divisor_d = abs_val(b, is_signed);
          quo_d     = abs_val(a, is_signed);
          qneg_d    = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
          rneg_d    = is_signed & a[XLEN-1];
          div0_d    = start_div0;
          ovf_d     = start_ovf;
          rem_d     = '0;
          cnt_d     = '0;
`ifdef DIV_EARLY_OUT_EN
          state_d   = (start_div0 || start_ovf) ? FIX : CALC;
`else
          state_d   = CALC;
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], step_qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        y_d     = op_q[1] ? rem_fix : quo_fix;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      y_q       <= y_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_div_unit_32bits.sv
// Directed bench for div_unit_32bits: results, latency, busy window, special
// cases, ignored start, mid-operation reset and back-to-back issue.
module tb_div_unit_32bits;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int vectors = 0;
  int errors  = 0;

  div_unit_32bits #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge, operands are then scrambled.
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Entered in the first cycle after start was sampled (cycle index 1).
  task automatic wait_done(output int lat, output int bc, input string tag);
    lat = 1;
    bc  = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    check({31'b0, done}, 32'd1, {tag, "_done_seen"});
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ex, input bit early, input string tag);
    int lat;
    int bc;
    int exp_lat;
    exp_lat = early ? EARLY_LAT : FULL_LAT;
    @(negedge clk);
    issue(o, av, bv);
    wait_done(lat, bc, tag);
    check(y, ex, {tag, "_y"});
    check(32'(lat), 32'(exp_lat), {tag, "_latency"});
    check(32'(bc), 32'(exp_lat - 1), {tag, "_busy_cycles"});
    check({31'b0, busy}, 32'd0, {tag, "_busy_in_done"});
    @(negedge clk);
    check({31'b0, done}, 32'd0, {tag, "_done_pulse"});
    check(y, ex, {tag, "_y_held"});
  endtask

  initial begin
    int lat;
    int bc;
    bit seen;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({31'b0, busy}, 32'd0, "reset_busy");
    check({31'b0, done}, 32'd0, "reset_done");
    check(y, 32'd0, "reset_y");
    rst = 1'b0;

    // Unsigned and signed arithmetic
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7");
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu_100_7");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, "div_m100_7");
    run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, "rem_m100_7");

    // Divide by zero
    run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "divu_5_0");
    run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, "rem_m5_0");
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_m5_0");
    run_op(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, "remu_5_0");

    // Signed overflow and its unsigned counterparts
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "rem_ovf");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "divu_ovf_ops");
    run_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "remu_ovf_ops");

    // Start pulsed at busy cycle 5 must be ignored
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    op    = OP_DIV;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc, "ignored_start");
    check(y, 32'd14, "ignored_start_y");
    check(32'(5 + lat), 32'(FULL_LAT), "ignored_start_latency");

    // Reset at iteration 10 aborts with no done
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({31'b0, busy}, 32'd0, "abort_busy");
    check({31'b0, done}, 32'd0, "abort_done");
    check(y, 32'd0, "abort_y");
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({31'b0, seen}, 32'd0, "abort_no_done");
    run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, "after_abort");

    // Back-to-back: second start issued in the done cycle of the first
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, bc, "b2b_first");
    check(y, 32'd14, "b2b_first_y");
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
    wait_done(lat, bc, "b2b_second");
    check(y, 32'h5555_5555, "b2b_second_y");
    check(32'(lat), 32'(FULL_LAT), "b2b_done_spacing");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
